// File: rtl/div_repsub_if.sv
// div_repsub_if -- handshake/bus bundle for the repeated-subtraction divider.
//   start       : begin an operation (sampled by the divider only in IDLE/DONE)
//   data_in     : dividend on the cycle after start is accepted, divisor after that
//   quotient    : quotient register
//   remainder   : remainder register (running dividend)
//   busy        : operation in progress (LDA, LDB, SUB)
//   done        : results valid
//   div_by_zero : the finished operation had a zero divisor
// Modports: master drives start/data_in, slave is the divider.
interface div_repsub_if #(
  parameter int W = 16
);
  logic         start;
  logic [W-1:0] data_in;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  modport master (
    output start,
    output data_in,
    input  quotient,
    input  remainder,
    input  busy,
    input  done,
    input  div_by_zero
  );

  modport slave (
    input  start,
    input  data_in,
    output quotient,
    output remainder,
    output busy,
    output done,
    output div_by_zero
  );
endinterface

// File: rtl/div_repsub.sv
// div_repsub -- sequential W-bit unsigned divider using repeated subtraction.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : div_repsub_if.slave (start, data_in, quotient, remainder,
//           busy, done, div_by_zero)
// Dividend and divisor arrive over data_in on the two cycles following an
// accepted start. Each SUB cycle removes one divisor from the running
// remainder and bumps the quotient, so latency is quotient + 3 edges.
module div_repsub #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  div_repsub_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LDA  = 3'd1,
    LDB  = 3'd2,
    SUB  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] r_q, r_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] q_q, q_d;
  logic         dz_q, dz_d;

  // Next-state and datapath update logic.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    b_d     = b_q;
    q_d     = q_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LDA;
        end else begin
          state_d = IDLE;
        end
      end
      LDA: begin
        r_d     = bus.data_in;
        dz_d    = 1'b0;
        state_d = LDB;
      end
      LDB: begin
        b_d     = bus.data_in;
        q_d     = {W{1'b0}};
        state_d = SUB;
      end
      SUB: begin
        // Zero divisor is checked first so it never loops forever.
        if (b_q == {W{1'b0}}) begin
          dz_d    = 1'b1;
          state_d = DONE;
        end else if (r_q >= b_q) begin
          // Guarded by the compare, so this never underflows.
          r_d     = r_q - b_q;
          q_d     = q_q + {{(W-1){1'b0}}, 1'b1};
          state_d = SUB;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Restart directly from DONE without revisiting IDLE.
        if (bus.start) begin
          state_d = LDA;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      q_q     <= {W{1'b0}};
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      b_q     <= b_d;
      q_q     <= q_d;
      dz_q    <= dz_d;
    end
  end

  // Outputs are decoded purely from registered state.
  assign bus.quotient    = q_q;
  assign bus.remainder   = r_q;
  assign bus.busy        = (state_q == LDA) || (state_q == LDB) || (state_q == SUB);
  assign bus.done        = (state_q == DONE);
  assign bus.div_by_zero = (state_q == DONE) && dz_q;

endmodule

// File: tb/tb_div_repsub.sv
module tb_div_repsub;

  localparam int W = 16;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    int          lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  exp_t sb[$];

  div_repsub_if #(.W(W)) bus ();

  div_repsub #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Wait for done; edges counts from the edge that accepted start.
  task automatic wait_done(inout int edges);
    while (bus.done !== 1'b1 && edges < 70000) begin
      @(posedge clk); #1;
      edges++;
      chk("busy_done_excl", {31'd0, bus.busy & bus.done}, 32'd0);
    end
    chk("done_timeout", {31'd0, bus.done}, 32'd1);
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    if (b == 16'd0) begin
      e.q = 16'd0; e.r = a; e.dz = 1'b1; e.lat = 3;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0; e.lat = int'(a / b) + 3;
    end
    return e;
  endfunction

  task automatic compare_result(input string tag, input int edges);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_q"},   {16'd0, bus.quotient},  {16'd0, e.q});
      chk({tag, "_r"},   {16'd0, bus.remainder}, {16'd0, e.r});
      chk({tag, "_dz"},  {31'd0, bus.div_by_zero}, {31'd0, e.dz});
      chk({tag, "_lat"}, edges, e.lat);
      chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    end
  endtask

  task automatic divide(input string tag, input logic [15:0] a, input logic [15:0] b);
    int edges;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk); #1;            // edge 0
    bus.start   = 1'b0;
    bus.data_in = a;
    sb.push_back(model(a, b));
    chk({tag, "_busy0"}, {31'd0, bus.busy}, 32'd1);
    chk({tag, "_done0"}, {31'd0, bus.done}, 32'd0);
    @(posedge clk); #1;            // edge 1: dividend captured
    chk({tag, "_lda"}, {16'd0, bus.remainder}, {16'd0, a});
    bus.data_in = b;
    @(posedge clk); #1;            // edge 2: divisor captured
    bus.data_in = 16'hA5A5;
    edges = 2;
    wait_done(edges);
    compare_result(tag, edges);
  endtask

  initial begin
    int edges;
    errors      = 0;
    checks      = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.data_in = 16'd0;
    #23;
    chk("rst_q",    {16'd0, bus.quotient},  32'd0);
    chk("rst_r",    {16'd0, bus.remainder}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy},      32'd0);
    chk("rst_done", {31'd0, bus.done},      32'd0);
    chk("rst_dz",   {31'd0, bus.div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    divide("d100_7",   16'd100, 16'd7);
    divide("d12_12",   16'd12,  16'd12);
    divide("d5_9",     16'd5,   16'd9);
    divide("d42_0",    16'd42,  16'd0);
    divide("d9_3",     16'd9,   16'd3);

    // start held high throughout 1000/10, then restart from DONE
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.data_in = 16'd1000;
    sb.push_back(model(16'd1000, 16'd10));
    @(posedge clk); #1;
    bus.data_in = 16'd10;
    @(posedge clk); #1;
    edges = 2;
    wait_done(edges);
    compare_result("hold", edges);
    @(posedge clk); #1;            // restart accepted from DONE
    chk("hold_restart_done", {31'd0, bus.done}, 32'd0);
    chk("hold_restart_busy", {31'd0, bus.busy}, 32'd1);
    bus.data_in = 16'd77;
    sb.push_back(model(16'd77, 16'd7));
    @(posedge clk); #1;
    chk("hold_restart_a", {16'd0, bus.remainder}, 32'd77);
    bus.start   = 1'b0;
    bus.data_in = 16'd7;
    @(posedge clk); #1;
    edges = 2;
    wait_done(edges);
    compare_result("d77_7", edges);

    // asynchronous reset in the middle of SUB
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.data_in = 16'd500;
    @(posedge clk); #1;
    bus.data_in = 16'd1;
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_q",    {16'd0, bus.quotient},  32'd0);
    chk("arst_r",    {16'd0, bus.remainder}, 32'd0);
    chk("arst_busy", {31'd0, bus.busy},      32'd0);
    chk("arst_done", {31'd0, bus.done},      32'd0);
    chk("arst_dz",   {31'd0, bus.div_by_zero}, 32'd0);
    chk("arst_state", {29'd0, dut.state_q},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    divide("d7_2", 16'd7, 16'd2);

    divide("d65535_65535", 16'hFFFF, 16'hFFFF);
    divide("d65535_1",     16'hFFFF, 16'd1);

    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
